accel_lock_arbiter: RTL and testbench
=====================================

# accel_lock_arbiter

Parametrised successor to the two-client accelerator lock. It arbitrates exclusive access to the shared encryption accelerator among `N_CLIENTS` cores. Lock requests are served strictly first-come-first-served through an internal request FIFO rather than first-free-wins. Every release is followed by a fixed-length accelerator scrub reset before the next grant. It sits between the cores' memory-mapped accelerator windows and the single accelerator port.

## Interface
- `N_CLIENTS`, 4: number of cores; legal range 2..255.
- `LOCK_ADDR`, 32'd84: control/status word address.
- `SCRUB_CYCLES`, 4: cycles `accel_rst_n_o` is held low after a release; legal range ≥1.
- `TIMEOUT_CYCLES`, 1024: idle-owner watchdog limit; used only with `LOCK_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `addr_in[N_CLIENTS]`  in  32  per-core address.
- `wr_en_in[N_CLIENTS]`  in  1  per-core write strobe.
- `select_in[N_CLIENTS]`  in  1  per-core accelerator-window select.
- `data_in[N_CLIENTS]`  in  32  per-core write data.
- `data_out[N_CLIENTS]`  out  32  per-core read data.
- `data_from_accel`  in  32  accelerator read data.
- `data_to_accel`  out  32  write data forwarded from the owner.
- `addr_o`  out  32  address forwarded from the owner.
- `wr_en_o`  out  1  write strobe forwarded from the owner.
- `accel_select_o`  out  1  select forwarded from the owner.
- `accel_rst_n_o`  out  1  active-low accelerator reset.
- `timeout_o`  out  1  one-cycle pulse on a watchdog release.

## Operation
- A **lock command** is a cycle with `select_in[i] && wr_en_in[i] && addr_in[i]==LOCK_ADDR`.
  - `data_in` = 1 is a request.
  - `data_in` = 0 is a release.
  - Other values are ignored.
- Owner ID width is `OW = $clog2(N_CLIENTS+1)`. The value `N_CLIENTS` encodes "free".
- **Request capture:** a request sets `pend[i]`. It is ignored when client i is the owner, already has `pend[i]` set, or is already in the FIFO.
- **FIFO push:** each cycle the lowest-index set `pend` bit is pushed into the FIFO and its `pend` bit is cleared.
  - Depth is `N_CLIENTS`, so the FIFO can never overflow.
  - Push and pop may occur in the same cycle.
- **FSM states:**
  - IDLE: if the FIFO is non-empty, pop the head into `owner` and go to LOCKED.
  - LOCKED: a release from the owner, or a watchdog expiry, sets `owner` = `N_CLIENTS` and goes to SCRUB. Releases from non-owners are ignored.
  - SCRUB: hold `accel_rst_n_o`=0 for `SCRUB_CYCLES` cycles (counter), then go to IDLE.
- **Forwarding (combinational):**
  - In LOCKED, `addr_o`, `wr_en_o` and `accel_select_o` come from the owner.
  - `data_to_accel` = `data_in[owner]` when the owner's `wr_en_in` is high, else 0.
  - Outside LOCKED all four forwarded outputs are 0. Lock commands are forwarded as well; the accelerator ignores `LOCK_ADDR`.
- **Read data (combinational):**
  - If `addr_in[i]==LOCK_ADDR`, `data_out[i]` is the status word:
    - [OW-1:0] = owner.
    - [16] = client i is pending or queued.
    - [17] = FSM in SCRUB.
    - [18] = sticky timeout flag for i.
    - All other bits are 0.
  - Otherwise the owner receives `data_from_accel` and all other clients receive 0.

## Timing
- **Reset values:**
  - FSM=IDLE, owner=`N_CLIENTS`, FIFO empty, `pend`=0, counters=0, flags=0.
  - `accel_rst_n_o`=0, `timeout_o`=0.
  - All forwarded outputs are 0.
  - `accel_rst_n_o` goes to 1 on the first clock edge after `rst` deasserts.
- **Grant latency** from a request on edge E, with the FSM idle and no contention:
  - `pend` is set at E.
  - The push happens at E+1.
  - The pop and `owner` update happen at E+2; forwarding is active from that point.
- **Release at edge R:**
  - `owner` is free at R.
  - `accel_rst_n_o` is low for cycles R..R+SCRUB_CYCLES-1.
  - IDLE is reached at R+SCRUB_CYCLES.
  - The next grant happens at R+SCRUB_CYCLES+1 at the earliest.
- **Simultaneous requests:** same-cycle requests are queued lowest index first and later granted in that order.
- **Request by the releasing owner:** a request from the owner in the cycle after its release is accepted and queued behind all earlier requesters.
- **Asserting `rst` mid-operation:** all state is cleared immediately, including FIFO, `pend` and scrub; `accel_rst_n_o` goes low asynchronously.

## Configuration
- Macro: `LOCK_TIMEOUT_EN`.
- **Defined:**
  - In LOCKED, a counter increments on each cycle in which `select_in[owner]` is 0 and clears whenever it is 1.
  - When the counter reaches `TIMEOUT_CYCLES`, the block forces a release, pulses `timeout_o` for one cycle, and sets the owner's sticky flag.
  - The sticky flag clears on that client's next accepted request.
- **Undefined:** no counter is present, `timeout_o` is tied to 0, and status bit [18] is always 0.

## Test plan
- **Reset:** assert `rst` → owner=4, `accel_rst_n_o`=0; deassert → `accel_rst_n_o`=1 next edge, status word reads 32'h4 on every client.
- **Simple lock:** client 2 writes 1 → `owner`=2 two edges later. Client 2 then writes addr 0x10 data 0xAB → `addr_o`=0x10, `data_to_accel`=0xAB. Client 1 reads a non-lock address → 0.
- **Contention:** clients 3, 1, 0 request in the same cycle while client 2 owns.
  - Grants go 0, 1, 3, in that order.
  - Each grant follows a 4-cycle `accel_rst_n_o` low pulse.
  - Status bit [16] is set for each client until it is granted.
- **Release rules:** a write of 0 from non-owner 1 → no effect. A write of 1 from owner 2 → ignored, no duplicate FIFO entry. A write of 0 from owner 2 → SCRUB, status bit [17]=1 for 4 cycles.
- **Reset mid-operation:** pulse `rst` during SCRUB with 2 entries queued → FIFO empties and `owner`=4; no grant occurs afterwards without new requests.
- **Watchdog (`LOCK_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** owner 1 goes idle for 8 cycles → `timeout_o` pulses and SCRUB starts. Client 1's status reads bit [18]=1, which clears on its next request.

Source files
------------

// File: rtl/accel_lock_arbiter.sv
// FCFS exclusive-access lock for a shared accelerator; each release is followed by a SCRUB_CYCLES accelerator reset.
// Grant lands two edges after an uncontended request; define LOCK_TIMEOUT_EN to add the idle-owner watchdog.
module accel_lock_arbiter #(
  parameter int          N_CLIENTS      = 4,
  parameter logic [31:0] LOCK_ADDR      = 32'd84,
  parameter int          SCRUB_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in   [N_CLIENTS],
  input  logic        wr_en_in  [N_CLIENTS],
  input  logic        select_in [N_CLIENTS],
  input  logic [31:0] data_in   [N_CLIENTS],
  output logic [31:0] data_out  [N_CLIENTS],
  input  logic [31:0] data_from_accel,
  output logic [31:0] data_to_accel,
  output logic [31:0] addr_o,
  output logic        wr_en_o,
  output logic        accel_select_o,
  output logic        accel_rst_n_o,
  output logic        timeout_o
);

  localparam int OW = $clog2(N_CLIENTS + 1);
  localparam int PW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(N_CLIENTS + 1);
  localparam int SW = $clog2(SCRUB_CYCLES + 1);
  localparam logic [OW-1:0] FREE = OW'(N_CLIENTS);

  if (N_CLIENTS < 2 || N_CLIENTS > 255 || SCRUB_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("accel_lock_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_SCRUB} state_t;

  state_t                r_state, w_state_nxt;
  logic [OW-1:0]         r_owner;
  logic [N_CLIENTS-1:0]  r_pend, r_queued;
  logic [OW-1:0]         r_fifo [N_CLIENTS];
  logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_scrub_cnt;
  logic                  r_accel_rst_n;

  logic [N_CLIENTS-1:0]  w_req, w_rel, w_is_owner, w_req_acc, w_push_oh, w_pop_oh, w_to_flag;
  logic [OW-1:0]         w_push_id, w_head;
  logic                  w_push, w_pop, w_owner_rel, w_wd_expire, w_release;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_CLIENTS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_req      = '0;
    w_rel      = '0;
    w_is_owner = '0;
    w_push_oh  = '0;
    w_push_id  = '0;
    w_pop_oh   = '0;
    w_head     = r_fifo[r_rd_ptr];
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_is_owner[i] = (r_owner == OW'(i));
      if (select_in[i] && wr_en_in[i] && addr_in[i] == LOCK_ADDR) begin
        w_req[i] = (data_in[i] == 32'd1);
        w_rel[i] = (data_in[i] == 32'd0);
      end
    end
    // Walk downwards so the lowest pending index wins the single push slot.
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_push_oh    = '0;
        w_push_oh[i] = 1'b1;
        w_push_id    = OW'(i);
      end
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_pop_oh[i] = w_pop && (w_head == OW'(i));
    end
  end

  assign w_push      = |r_pend;
  assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
  assign w_req_acc   = w_req & ~r_pend & ~r_queued & ~w_is_owner;
  assign w_owner_rel = (r_state == ST_LOCKED) && (|(w_rel & w_is_owner));
  assign w_release   = w_owner_rel || w_wd_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pop) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_release) w_state_nxt = ST_SCRUB;
      ST_SCRUB:  if (r_scrub_cnt == SW'(SCRUB_CYCLES - 1)) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner       <= FREE;
      r_pend        <= '0;
      r_queued      <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_scrub_cnt   <= '0;
      r_accel_rst_n <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) r_fifo[i] <= '0;
    end else begin
      r_accel_rst_n <= (w_state_nxt != ST_SCRUB);
      r_pend        <= (r_pend & ~w_push_oh) | w_req_acc;
      r_queued      <= (r_queued | w_push_oh) & ~w_pop_oh;
      r_scrub_cnt   <= (r_state == ST_SCRUB) ? r_scrub_cnt + 1'b1 : '0;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_id;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_owner  <= w_head;
      end else if (w_release) begin
        r_owner  <= FREE;
      end
      // Each client occupies at most one slot, so depth N_CLIENTS never overflows.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]        r_wd_cnt;
  logic                 r_timeout;
  logic [N_CLIENTS-1:0] r_to_flag;
  logic                 w_owner_sel;

  always_comb begin
    w_owner_sel = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (w_is_owner[i] && select_in[i]) w_owner_sel = 1'b1;
    end
  end

  assign w_wd_expire = (r_state == ST_LOCKED) && !w_owner_sel && (r_wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
      r_to_flag <= '0;
    end else begin
      r_timeout <= w_wd_expire;
      r_to_flag <= (r_to_flag & ~w_req_acc) | ({N_CLIENTS{w_wd_expire}} & w_is_owner);
      if (r_state != ST_LOCKED || w_owner_sel || w_wd_expire) r_wd_cnt <= '0;
      else                                                   r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign timeout_o = r_timeout;
  assign w_to_flag = r_to_flag;
`else
  assign w_wd_expire = 1'b0;
  assign timeout_o   = 1'b0;
  assign w_to_flag   = '0;
`endif

  assign accel_rst_n_o = r_accel_rst_n;

  always_comb begin
    addr_o         = '0;
    wr_en_o        = 1'b0;
    accel_select_o = 1'b0;
    data_to_accel  = '0;
    if (r_state == ST_LOCKED) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (w_is_owner[i]) begin
          addr_o         = addr_in[i];
          wr_en_o        = wr_en_in[i];
          accel_select_o = select_in[i];
          data_to_accel  = wr_en_in[i] ? data_in[i] : '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      data_out[i] = '0;
      if (addr_in[i] == LOCK_ADDR) begin
        data_out[i][OW-1:0] = r_owner;
        data_out[i][16]     = r_pend[i] | r_queued[i];
        data_out[i][17]     = (r_state == ST_SCRUB);
        data_out[i][18]     = w_to_flag[i];
      end else if (w_is_owner[i]) begin
        data_out[i] = data_from_accel;
      end
    end
  end

endmodule

// File: tb/tb_accel_lock_arbiter.sv
// Directed bench for accel_lock_arbiter: reset, grant latency, forwarding, FCFS contention, release rules, mid-op reset, watchdog.
module tb_accel_lock_arbiter;
  localparam int          N  = 4;
  localparam logic [31:0] LA = 32'd84;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_in   [N];
  logic        wr_en_in  [N];
  logic        select_in [N];
  logic [31:0] data_in   [N];
  logic [31:0] data_out  [N];
  logic [31:0] data_from_accel;
  logic [31:0] data_to_accel;
  logic [31:0] addr_o;
  logic        wr_en_o;
  logic        accel_select_o;
  logic        accel_rst_n_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  accel_lock_arbiter #(
    .N_CLIENTS(4), .LOCK_ADDR(32'd84), .SCRUB_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_in(addr_in), .wr_en_in(wr_en_in), .select_in(select_in), .data_in(data_in),
    .data_out(data_out), .data_from_accel(data_from_accel), .data_to_accel(data_to_accel),
    .addr_o(addr_o), .wr_en_o(wr_en_o), .accel_select_o(accel_select_o),
    .accel_rst_n_o(accel_rst_n_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int own, input bit pq, input bit sc, input bit to);
    return 32'(own) | {13'b0, to, sc, pq, 16'b0};
  endfunction

  task automatic set_idle();
    for (int i = 0; i < N; i++) begin
      addr_in[i]   = LA;
      wr_en_in[i]  = 1'b0;
      select_in[i] = 1'b0;
      data_in[i]   = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int c, input logic [31:0] v);
    select_in[c] = 1'b1;
    wr_en_in[c]  = 1'b1;
    addr_in[c]   = LA;
    data_in[c]   = v;
  endtask

  task automatic lock_cmd(input int c, input logic [31:0] v);
    drive_cmd(c, v);
    cyc();
    set_idle();
    #1;
  endtask

  // Releases owner c, optionally re-requests from c on the following edge, then measures the scrub window.
  task automatic release_scrub(input int c, input bit rereq);
    int lo;
    int sc;
    lo = 0;
    sc = 0;
    lock_cmd(c, 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (accel_rst_n_o && !data_out[c][17]) break;
      if (!accel_rst_n_o) lo++;
      if (data_out[c][17]) sc++;
      if (k == 0 && rereq) drive_cmd(c, 32'd1);
      cyc();
      set_idle();
      #1;
    end
    check($sformatf("scrub_rstn_len_%0d", c), 32'(lo), 32'd4);
    check($sformatf("scrub_bit17_len_%0d", c), 32'(sc), 32'd4);
  endtask

  task automatic grant_check(input int c);
    check($sformatf("idle_queued_%0d", c), data_out[c], st(4, 1, 0, 0));
    cyc();
    check($sformatf("grant_%0d", c), data_out[c], st(c, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  initial begin
    int k;
    set_idle();
    data_from_accel = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rstn", 32'(accel_rst_n_o), 32'd0);
    check("rst_status", data_out[0], st(4, 0, 0, 0));
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_addr_o", addr_o, 32'd0);
    rst = 1'b0;
    #1;
    check("rstn_before_edge", 32'(accel_rst_n_o), 32'd0);
    cyc();
    check("rstn_after_edge", 32'(accel_rst_n_o), 32'd1);
    for (int i = 0; i < N; i++) check($sformatf("rst_status_c%0d", i), data_out[i], 32'h4);

    // Uncontended request from client 2
    lock_cmd(2, 32'd1);
    check("req_pend", data_out[2], st(4, 1, 0, 0));
    cyc();
    check("req_queued", data_out[2], st(4, 1, 0, 0));
    check("req_no_fwd", 32'(accel_select_o), 32'd0);
    cyc();
    check("grant_2_latency", data_out[2], st(2, 0, 0, 0));

    select_in[2] = 1'b1;
    wr_en_in[2]  = 1'b1;
    addr_in[2]   = 32'h10;
    data_in[2]   = 32'hAB;
    addr_in[1]   = 32'h20;
    data_from_accel = 32'h55AA;
    #1;
    check("fwd_addr", addr_o, 32'h10);
    check("fwd_data", data_to_accel, 32'hAB);
    check("fwd_wr", 32'(wr_en_o), 32'd1);
    check("fwd_sel", 32'(accel_select_o), 32'd1);
    check("rd_nonowner", data_out[1], 32'd0);
    wr_en_in[2] = 1'b0;
    #1;
    check("fwd_data_nowr", data_to_accel, 32'd0);
    check("rd_owner", data_out[2], 32'h55AA);
    set_idle();
    data_from_accel = '0;
    #1;

    // Release rules
    lock_cmd(1, 32'd0);
    check("nonowner_release", data_out[2], st(2, 0, 0, 0));
    check("nonowner_release_rstn", 32'(accel_rst_n_o), 32'd1);
    lock_cmd(2, 32'd1);
    cyc();
    cyc();
    check("owner_rereq_ignored", data_out[2], st(2, 0, 0, 0));

    // Contention: 3, 1, 0 in the same cycle while 2 owns
    drive_cmd(3, 32'd1);
    drive_cmd(1, 32'd1);
    drive_cmd(0, 32'd1);
    cyc();
    set_idle();
    #1;
    check("cont_pend_0", data_out[0], st(2, 1, 0, 0));
    check("cont_pend_1", data_out[1], st(2, 1, 0, 0));
    check("cont_pend_3", data_out[3], st(2, 1, 0, 0));
    cyc();
    cyc();
    cyc();
    release_scrub(2, 1'b0);
    grant_check(0);
    check("wait_1_under_0", data_out[1], st(0, 1, 0, 0));
    check("wait_3_under_0", data_out[3], st(0, 1, 0, 0));
    release_scrub(0, 1'b1);
    grant_check(1);
    check("rereq_0_queued", data_out[0], st(1, 1, 0, 0));
    release_scrub(1, 1'b0);
    grant_check(3);
    release_scrub(3, 1'b0);
    grant_check(0);

    // Reset during SCRUB with two entries queued
    drive_cmd(1, 32'd1);
    drive_cmd(2, 32'd1);
    cyc();
    set_idle();
    #1;
    cyc();
    cyc();
    lock_cmd(0, 32'd0);
    cyc();
    check("mid_queued_scrub", data_out[2], st(4, 1, 1, 0));
    rst = 1'b1;
    #1;
    check("mid_rst_c1", data_out[1], st(4, 0, 0, 0));
    check("mid_rst_c2", data_out[2], st(4, 0, 0, 0));
    check("mid_rst_rstn", 32'(accel_rst_n_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) cyc();
    check("mid_after_c1", data_out[1], st(4, 0, 0, 0));
    check("mid_after_c2", data_out[2], st(4, 0, 0, 0));
    check("mid_after_rstn", 32'(accel_rst_n_o), 32'd1);
    check("mid_after_sel", 32'(accel_select_o), 32'd0);

`ifdef LOCK_TIMEOUT_EN
    lock_cmd(1, 32'd1);
    cyc();
    cyc();
    check("wd_grant", data_out[1], st(1, 0, 0, 0));
    k = 0;
    while (!timeout_o && k < 30) begin
      cyc();
      k++;
    end
    check("wd_idle_cycles", 32'(k), 32'd8);
    check("wd_status", data_out[1], st(4, 0, 1, 1));
    cyc();
    check("wd_pulse_end", 32'(timeout_o), 32'd0);
    repeat (5) cyc();
    check("wd_sticky_idle", data_out[1], st(4, 0, 0, 1));
    lock_cmd(1, 32'd1);
    check("wd_sticky_clear", data_out[1], st(4, 1, 0, 0));
`else
    lock_cmd(1, 32'd1);
    cyc();
    cyc();
    k = 0;
    repeat (12) begin
      cyc();
      if (timeout_o) k++;
    end
    check("no_wd_pulses", 32'(k), 32'd0);
    check("no_wd_owner_kept", data_out[1], st(1, 0, 0, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
